// File: rtl/cfa_scan_ctrl.sv
// Raster-scan window sequencer for the CFA demosaic pipeline: tap reads, update strobes,
// Bayer phase and latency-matched writes. Define CFA_MIRROR_BORDER_EN for mirrored borders (default clamps).
module cfa_scan_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DIM_W  = 11,
  parameter int WIN    = 5,
  parameter int WR_LAT = 6,
  parameter int CH     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  input  logic [DIM_W-1:0]        rowMax,
  input  logic [DIM_W-1:0]        colMax,
  input  logic [1:0]              patternSelect,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       readAddress,
  output logic                    readValid,
  output logic [$clog2(WIN)-1:0]  tapRow,
  output logic [$clog2(WIN)-1:0]  tapCol,
  output logic                    colUpdate,
  output logic                    rowUpdate,
  output logic [1:0]              bayerPhase,
  output logic [ADDR_W-1:0]       writeAddress,
  output logic [CH-1:0]           writeEnable
);

  localparam int TW = $clog2(WIN);
  localparam int R  = WIN / 2;
  localparam int IW = DIM_W + 2;
  localparam int DW = $clog2(WR_LAT + 1);
  localparam int PW = 2 * DIM_W;
  localparam logic signed [IW-1:0] R_S   = IW'(R);
  localparam logic signed [IW-1:0] ONE_S = IW'(1);

  typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_UPDATE, S_FETCH, S_DRAIN, S_DONE} state_t;

  function automatic logic [DIM_W-1:0] border_map(input logic signed [IW-1:0] i,
                                                  input logic [DIM_W-1:0] n);
    logic signed [IW-1:0] last;
    logic signed [IW-1:0] m;
    last = $signed({2'b00, n}) - ONE_S;
`ifdef CFA_MIRROR_BORDER_EN
    if (i < 0)         m = -i;
    else if (i > last) m = (last <<< 1) - i;
    else               m = i;
`else
    if (i < 0)         m = '0;
    else if (i > last) m = last;
    else               m = i;
`endif
    return m[DIM_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, rmax_q, rmax_d, cmax_q, cmax_d;
  logic [TW-1:0]     k_q, k_d, t_q, t_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [1:0]        ps_q, ps_d;

  logic              rd_vld_q, rd_vld_d, col_upd_q, col_upd_d, row_upd_q, row_upd_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [TW-1:0]     tap_row_q, tap_row_d, tap_col_q, tap_col_d;
  logic [1:0]        phase_q, phase_d;

  logic              wr_vld_q  [WR_LAT];
  logic              wr_vld_d  [WR_LAT];
  logic [ADDR_W-1:0] wr_addr_q [WR_LAT];
  logic [ADDR_W-1:0] wr_addr_d [WR_LAT];

  logic signed [IW-1:0] img_row, img_col;
  logic [DIM_W-1:0]     mr, mc;
  logic [PW-1:0]        prod;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rmax_d    = rmax_q;
    cmax_d    = cmax_q;
    k_d       = k_q;
    t_d       = t_q;
    pix_d     = pix_q;
    drain_d   = drain_q;
    ps_d      = ps_q;
    rd_vld_d  = rd_vld_q;
    rd_addr_d = rd_addr_q;
    tap_row_d = tap_row_q;
    tap_col_d = tap_col_q;
    col_upd_d = col_upd_q;
    row_upd_d = row_upd_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = done_q;
    for (int i = 0; i < WR_LAT; i++) begin
      wr_vld_d[i]  = wr_vld_q[i];
      wr_addr_d[i] = wr_addr_q[i];
    end
    img_row = '0;
    img_col = '0;
    mr      = '0;
    mc      = '0;
    prod    = '0;

    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (start && rowMax >= DIM_W'(WIN) && colMax >= DIM_W'(WIN)) begin
            rmax_d  = rowMax;
            cmax_d  = colMax;
            ps_d    = patternSelect;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            t_d     = '0;
            pix_d   = '0;
            state_d = S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (t_q == TW'(WIN - 1)) begin
            t_d = '0;
            if (k_q == TW'(WIN - 1)) state_d = S_UPDATE;
            else                     k_d = k_q + 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
        S_UPDATE: begin
          pix_d = pix_q + 1'b1;
          t_d   = '0;
          if (col_q < cmax_q - 1'b1) begin
            col_d   = col_q + 1'b1;
            k_d     = TW'(WIN - 1);
            state_d = S_FETCH;
          end else begin
            col_d = '0;
            row_d = row_q + 1'b1;
            k_d   = '0;
            if (row_q == rmax_q - 1'b1) begin
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              state_d = S_PREFILL;
            end
          end
        end
        S_FETCH: begin
          if (t_q == TW'(WIN - 1)) state_d = S_UPDATE;
          else                     t_d = t_q + 1'b1;
        end
        S_DRAIN: begin
          if (drain_q == DW'(WR_LAT - 1)) state_d = S_DONE;
          else                            drain_d = drain_q + 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // Raster order makes the pixel counter equal to row*colMax+col.
      wr_vld_d[0]  = (state_q == S_UPDATE);
      wr_addr_d[0] = (state_q == S_UPDATE) ? pix_q : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        wr_vld_d[i]  = wr_vld_q[i-1];
        wr_addr_d[i] = wr_addr_q[i-1];
      end

      // FETCH reuses the prefill formula with k pinned at WIN-1, giving column col+R.
      img_row = $signed({2'b00, row_d}) - R_S + $signed({{(IW-TW){1'b0}}, t_d});
      img_col = $signed({2'b00, col_d}) - R_S + $signed({{(IW-TW){1'b0}}, k_d});
      mr      = border_map(img_row, rmax_d);
      mc      = border_map(img_col, cmax_d);
      prod    = PW'(mr) * PW'(cmax_d) + PW'(mc);

      rd_vld_d  = (state_d == S_PREFILL) || (state_d == S_FETCH);
      rd_addr_d = rd_vld_d ? ADDR_W'(prod) : '0;
      tap_row_d = rd_vld_d ? t_d : '0;
      tap_col_d = rd_vld_d ? k_d : '0;
      col_upd_d = (state_d == S_UPDATE);
      row_upd_d = col_upd_d && (col_d == cmax_d - 1'b1);
      phase_d   = col_upd_d ? {row_d[0] ^ ps_d[1], col_d[0] ^ ps_d[0]} : 2'b00;
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rmax_q    <= '0;
      cmax_q    <= '0;
      k_q       <= '0;
      t_q       <= '0;
      pix_q     <= '0;
      drain_q   <= '0;
      ps_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      tap_row_q <= '0;
      tap_col_q <= '0;
      col_upd_q <= 1'b0;
      row_upd_q <= 1'b0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < WR_LAT; i++) begin
        wr_vld_q[i]  <= 1'b0;
        wr_addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rmax_q    <= rmax_d;
      cmax_q    <= cmax_d;
      k_q       <= k_d;
      t_q       <= t_d;
      pix_q     <= pix_d;
      drain_q   <= drain_d;
      ps_q      <= ps_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      tap_row_q <= tap_row_d;
      tap_col_q <= tap_col_d;
      col_upd_q <= col_upd_d;
      row_upd_q <= row_upd_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < WR_LAT; i++) begin
        wr_vld_q[i]  <= wr_vld_d[i];
        wr_addr_q[i] <= wr_addr_d[i];
      end
    end
  end

  // Stall masks the held event so it fires in the first unstalled cycle.
  assign readValid    = rd_vld_q & ~stall;
  assign colUpdate    = col_upd_q & ~stall;
  assign rowUpdate    = row_upd_q & ~stall;
  assign done         = done_q & ~stall;
  assign writeEnable  = {CH{wr_vld_q[WR_LAT-1] & ~stall}};
  assign busy         = busy_q;
  assign readAddress  = rd_addr_q;
  assign tapRow       = tap_row_q;
  assign tapCol       = tap_col_q;
  assign bayerPhase   = phase_q;
  assign writeAddress = wr_addr_q[WR_LAT-1];

endmodule

// File: tb/tb_cfa_scan_ctrl.sv
// Directed bench for cfa_scan_ctrl (WIN=5, WR_LAT=6, 5x6 frame); border expectations follow CFA_MIRROR_BORDER_EN.
module tb_cfa_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [10:0] rowMax, colMax;
  logic [1:0]  patternSelect;
  logic        busy, done, readValid, colUpdate, rowUpdate;
  logic [16:0] readAddress, writeAddress;
  logic [2:0]  tapRow, tapCol, writeEnable;
  logic [1:0]  bayerPhase;

  always #5 clk = ~clk;

  cfa_scan_ctrl #(.ADDR_W(17), .DIM_W(11), .WIN(5), .WR_LAT(6), .CH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rowMax(rowMax), .colMax(colMax), .patternSelect(patternSelect),
    .busy(busy), .done(done), .readAddress(readAddress), .readValid(readValid),
    .tapRow(tapRow), .tapCol(tapCol), .colUpdate(colUpdate), .rowUpdate(rowUpdate),
    .bayerPhase(bayerPhase), .writeAddress(writeAddress), .writeEnable(writeEnable)
  );

`ifdef CFA_MIRROR_BORDER_EN
  localparam int EXP_C1 = 14, EXP_C27 = 15, EXP_C55 = 15;
`else
  localparam int EXP_C1 = 0,  EXP_C27 = 3,  EXP_C55 = 17;
`endif
  localparam int EXP_C25 = 14;

  int total = 0;
  int bad   = 0;

  int n_rd, rd_in_stall, n_col, n_row, first_col, last_row, n_wr, first_wr, wr_err;
  int n_done, done_cyc, n_busy, busy_fall, seen_busy, post_rst;
  logic [1:0]  phase1, phase2;
  logic [16:0] addr_log [0:511];
  logic [2:0]  trow_log [0:511];
  logic        vld_log  [0:511];

  task automatic run_frame(input logic [10:0] rmax, input logic [10:0] cmax,
                           input int stall_at, input int stall_len,
                           input int restart_at, input int reset_at, input int ncyc);
    n_rd = 0; rd_in_stall = 0; n_col = 0; n_row = 0; first_col = -1; last_row = -1;
    n_wr = 0; first_wr = -1; wr_err = 0; n_done = 0; done_cyc = -1; n_busy = 0;
    busy_fall = -1; seen_busy = 0; post_rst = 0; phase1 = 2'bxx; phase2 = 2'bxx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rowMax = rmax;
      colMax = cmax;
      start  = (c == 0) || (c == restart_at);
      stall  = (c >= stall_at) && (c < stall_at + stall_len);
      rst    = (c == reset_at) ? 1'b0 : 1'b1;
      #1;
      if (c < 512) begin
        addr_log[c] = readAddress;
        trow_log[c] = tapRow;
        vld_log[c]  = readValid;
      end
      if (readValid) begin
        n_rd++;
        if (stall) rd_in_stall++;
      end
      if (colUpdate) begin
        if (n_col == 0) begin first_col = c; phase1 = bayerPhase; end
        if (n_col == 1) phase2 = bayerPhase;
        n_col++;
      end
      if (rowUpdate) begin
        n_row++;
        last_row = c;
      end
      if (writeEnable != 3'b000) begin
        if (n_wr == 0) first_wr = c;
        if (writeEnable != 3'b111 || writeAddress != 17'(n_wr)) wr_err++;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (busy) begin
        n_busy++;
        seen_busy = 1;
      end else if (seen_busy != 0 && busy_fall < 0) begin
        busy_fall = c;
      end
      if (reset_at >= 0 && c > reset_at &&
          (busy || readValid || colUpdate || rowUpdate || done || writeEnable != 3'b000 ||
           readAddress != 17'd0 || writeAddress != 17'd0))
        post_rst++;
      if (n_done > 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_reset;
    logic [49:0] outs;
    rst = 1'b0; start = 1'b1; stall = 1'b0; rowMax = 11'd5; colMax = 11'd6;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      outs = {busy, done, readValid, colUpdate, rowUpdate, writeEnable, readAddress,
              writeAddress, tapRow, tapCol, bayerPhase};
      total++;
      if (outs !== 50'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    end
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({busy, readValid} !== 2'b00) begin
        bad++; $display("FAIL reset_idle got=%b want=00", {busy, readValid});
      end
    end
    $display("test_reset complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_frame;
    run_frame(11'd5, 11'd6, -10, 0, -1, -1, 400);
    total++; if (first_col !== 26)  begin bad++; $display("FAIL frame_first_col got=%0d want=26", first_col); end
    total++; if (n_col !== 30)      begin bad++; $display("FAIL frame_n_col got=%0d want=30", n_col); end
    total++; if (n_row !== 5)       begin bad++; $display("FAIL frame_n_row got=%0d want=5", n_row); end
    total++; if (last_row !== 280)  begin bad++; $display("FAIL frame_last_row got=%0d want=280", last_row); end
    total++; if (n_wr !== 30)       begin bad++; $display("FAIL frame_n_wr got=%0d want=30", n_wr); end
    total++; if (first_wr !== 32)   begin bad++; $display("FAIL frame_first_wr got=%0d want=32", first_wr); end
    total++; if (wr_err !== 0)      begin bad++; $display("FAIL frame_wr_order got=%0d want=0", wr_err); end
    total++; if (done_cyc !== 287)  begin bad++; $display("FAIL frame_done got=%0d want=287", done_cyc); end
    total++; if (n_done !== 1)      begin bad++; $display("FAIL frame_n_done got=%0d want=1", n_done); end
    total++; if (busy_fall !== 288) begin bad++; $display("FAIL frame_busy_fall got=%0d want=288", busy_fall); end
    total++; if (n_rd !== 250)      begin bad++; $display("FAIL frame_n_rd got=%0d want=250", n_rd); end
    total++; if (vld_log[1] !== 1'b1) begin bad++; $display("FAIL frame_first_rd_valid got=%b want=1", vld_log[1]); end
    $display("test_frame complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_border;
    // Taps below reuse the log captured by test_frame.
    total++; if (addr_log[1] !== 17'(EXP_C1))   begin bad++; $display("FAIL border_c1 got=%0d want=%0d", addr_log[1], EXP_C1); end
    total++; if (addr_log[25] !== 17'(EXP_C25)) begin bad++; $display("FAIL border_c25 got=%0d want=%0d", addr_log[25], EXP_C25); end
    total++; if (addr_log[27] !== 17'(EXP_C27)) begin bad++; $display("FAIL border_c27 got=%0d want=%0d", addr_log[27], EXP_C27); end
    total++; if (addr_log[55] !== 17'(EXP_C55)) begin bad++; $display("FAIL border_c55 got=%0d want=%0d", addr_log[55], EXP_C55); end
    total++; if (trow_log[55] !== 3'd4)         begin bad++; $display("FAIL border_c55_tap got=%0d want=4", trow_log[55]); end
    total++; if (phase1 !== 2'b11) begin bad++; $display("FAIL phase_px00 got=%b want=11", phase1); end
    total++; if (phase2 !== 2'b10) begin bad++; $display("FAIL phase_px01 got=%b want=10", phase2); end
    $display("test_border complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stall;
    run_frame(11'd5, 11'd6, 27, 3, -1, -1, 400);
    total++; if (rd_in_stall !== 0)     begin bad++; $display("FAIL stall_rd got=%0d want=0", rd_in_stall); end
    total++; if (vld_log[28] !== 1'b0)  begin bad++; $display("FAIL stall_vld28 got=%b want=0", vld_log[28]); end
    total++; if (addr_log[30] !== 17'(EXP_C27)) begin bad++; $display("FAIL stall_resume_addr got=%0d want=%0d", addr_log[30], EXP_C27); end
    total++; if (trow_log[30] !== 3'd0) begin bad++; $display("FAIL stall_resume_tap got=%0d want=0", trow_log[30]); end
    total++; if (first_wr !== 35)       begin bad++; $display("FAIL stall_first_wr got=%0d want=35", first_wr); end
    total++; if (last_row !== 283)      begin bad++; $display("FAIL stall_last_row got=%0d want=283", last_row); end
    total++; if (done_cyc !== 290)      begin bad++; $display("FAIL stall_done got=%0d want=290", done_cyc); end
    total++; if (n_rd !== 250)          begin bad++; $display("FAIL stall_n_rd got=%0d want=250", n_rd); end
    total++; if (n_wr !== 30 || wr_err !== 0) begin bad++; $display("FAIL stall_writes got=%0d/%0d want=30/0", n_wr, wr_err); end
    $display("test_stall complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reject;
    run_frame(11'd5, 11'd4, -10, 0, -1, -1, 15);
    total++; if (n_busy !== 0 || n_rd !== 0) begin bad++; $display("FAIL reject_col got=%0d/%0d want=0/0", n_busy, n_rd); end
    run_frame(11'd4, 11'd6, -10, 0, -1, -1, 15);
    total++; if (n_busy !== 0 || n_rd !== 0) begin bad++; $display("FAIL reject_row got=%0d/%0d want=0/0", n_busy, n_rd); end
    $display("test_reject complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_restart_ignored;
    run_frame(11'd5, 11'd6, -10, 0, 100, -1, 400);
    total++; if (n_col !== 30)     begin bad++; $display("FAIL restart_n_col got=%0d want=30", n_col); end
    total++; if (done_cyc !== 287) begin bad++; $display("FAIL restart_done got=%0d want=287", done_cyc); end
    total++; if (n_rd !== 250)     begin bad++; $display("FAIL restart_n_rd got=%0d want=250", n_rd); end
    $display("test_restart_ignored complete total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_midframe_reset;
    run_frame(11'd5, 11'd6, -10, 0, -1, 100, 150);
    total++; if (post_rst !== 0) begin bad++; $display("FAIL midrst_activity got=%0d want=0", post_rst); end
    total++; if (n_col !== 10)   begin bad++; $display("FAIL midrst_n_col got=%0d want=10", n_col); end
    total++; if (n_wr !== 9)     begin bad++; $display("FAIL midrst_n_wr got=%0d want=9", n_wr); end
    total++; if (n_done !== 0)   begin bad++; $display("FAIL midrst_done got=%0d want=0", n_done); end
    $display("test_midframe_reset complete total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; rowMax = 11'd5; colMax = 11'd6;
    patternSelect = 2'b11;
    test_reset();
    test_frame();
    test_border();
    test_stall();
    test_reject();
    test_restart_ignored();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
